// File: rtl/audio_pkg.sv
// Shared audio definitions for the codec ADC and DAC paths: sample width and
// serial-frame FSM encoding.
package audio_pkg;

  localparam int AUDIO_SAMPLE_BITS = 16;
  localparam int AUDIO_CNTR_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2
  } audio_state_e;

endpackage

// File: rtl/audio_adc_rx_if.sv
// Captured-sample handshake between the ADC receiver and its consumer.
interface audio_adc_rx_if #(
  parameter int SAMPLE_BITS = audio_pkg::AUDIO_SAMPLE_BITS
);

  logic signed [SAMPLE_BITS-1:0] left;
  logic signed [SAMPLE_BITS-1:0] right;
  logic                          valid;
  logic                          ready;
  logic                          overrun;

  modport master (
    output left,
    output right,
    output valid,
    output overrun,
    input  ready
  );

  modport slave (
    input  left,
    input  right,
    input  valid,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/bclk_sync.sv
// Brings codec BCLK and ADC data into the clk domain; reports BCLK edges with
// data taken from the same delayed stage so bit and edge stay aligned.
module bclk_sync (
  input  logic clk,
  input  logic rst,
  input  logic bclk_i,
  input  logic dat_i,
  output logic rise_o,
  output logic fall_o,
  output logic dat_o
);

  logic [2:0] bclk_q;
  logic [1:0] dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_q <= '0;
      dat_q  <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], bclk_i};
      dat_q  <= {dat_q[0], dat_i};
    end
  end

  // bclk_q[1] is the synchronized level, bclk_q[2] the edge-detect history
  assign rise_o = bclk_q[1] & ~bclk_q[2];
  assign fall_o = ~bclk_q[1] & bclk_q[2];
  assign dat_o  = dat_q[1];

endmodule

// File: rtl/audio_adc_rx.sv
// Codec ADC serial receiver: issues a one-BCLK frame-sync pulse per request,
// shifts in left/right samples MSB first and presents them with valid/ready.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS
) (
  input  logic                          clk25,
  input  logic                          reset25,
  input  logic                          codec_bclk_i,
  input  logic                          codec_adcdat,
  output logic                          codec_adclrc,
  input  logic                          audio_sample_clk,
  output logic signed [SAMPLE_BITS-1:0] audio_left_in,
  output logic signed [SAMPLE_BITS-1:0] audio_right_in,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          overrun
);

  localparam logic [AUDIO_CNTR_W-1:0] HALF_BITS = AUDIO_CNTR_W'(SAMPLE_BITS);
  localparam logic [AUDIO_CNTR_W-1:0] LAST_BIT  = AUDIO_CNTR_W'(2 * SAMPLE_BITS - 1);

  logic bclk_rise;
  logic bclk_fall;
  logic bclk_dat;

  bclk_sync u_bclk_sync (
    .clk    (clk25),
    .rst    (reset25),
    .bclk_i (codec_bclk_i),
    .dat_i  (codec_adcdat),
    .rise_o (bclk_rise),
    .fall_o (bclk_fall),
    .dat_o  (bclk_dat)
  );

  audio_state_e                  state_q;
  logic                          start_pending_q;
  logic                          samp_prev_q;
  logic                          lrc_q;
  logic                          valid_q;
  logic                          overrun_q;
  logic [AUDIO_CNTR_W-1:0]       bit_cntr_q;
  logic signed [SAMPLE_BITS-1:0] left_sr_q;
  logic signed [SAMPLE_BITS-1:0] right_sr_q;
  logic signed [SAMPLE_BITS-1:0] left_q;
  logic signed [SAMPLE_BITS-1:0] right_q;

  logic                          samp_rise;
  logic                          frame_start;
  logic                          capture;
  logic                          last_bit;
  logic signed [SAMPLE_BITS-1:0] left_sr_d;
  logic signed [SAMPLE_BITS-1:0] right_sr_d;

  assign samp_rise   = audio_sample_clk & ~samp_prev_q;
  assign frame_start = (state_q == ST_IDLE) && bclk_fall && start_pending_q;
  assign capture     = bclk_rise && (state_q != ST_IDLE);
  assign last_bit    = capture && (state_q == ST_SHIFT) && (bit_cntr_q == LAST_BIT);

  // The final right bit is folded in combinationally so the output registers
  // load in the same cycle as the last capture.
  always_comb begin
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    if (capture) begin
      if (bit_cntr_q < HALF_BITS) begin
        left_sr_d = {left_sr_q[SAMPLE_BITS-2:0], bclk_dat};
      end else begin
        right_sr_d = {right_sr_q[SAMPLE_BITS-2:0], bclk_dat};
      end
    end
  end

  always_ff @(posedge clk25 or posedge reset25) begin
    if (reset25) begin
      state_q         <= ST_IDLE;
      start_pending_q <= 1'b0;
      samp_prev_q     <= 1'b0;
      lrc_q           <= 1'b0;
      valid_q         <= 1'b0;
      overrun_q       <= 1'b0;
      bit_cntr_q      <= '0;
      left_sr_q       <= '0;
      right_sr_q      <= '0;
      left_q          <= '0;
      right_q         <= '0;
    end else begin
      samp_prev_q <= audio_sample_clk;
      left_sr_q   <= left_sr_d;
      right_sr_q  <= right_sr_d;

      // A request arriving in the very cycle a frame starts queues another frame
      if (samp_rise) begin
        start_pending_q <= 1'b1;
      end else if (frame_start) begin
        start_pending_q <= 1'b0;
      end

      if (lrc_q && bclk_fall) begin
        lrc_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q    <= ST_SYNC;
            lrc_q      <= 1'b1;
            bit_cntr_q <= '0;
          end
        end
        ST_SYNC: begin
          if (bclk_rise) begin
            state_q    <= ST_SHIFT;
            bit_cntr_q <= bit_cntr_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bclk_rise) begin
            bit_cntr_q <= bit_cntr_q + 1'b1;
            if (last_bit) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A pair accepted in the completion cycle counts as consumed, not overrun
      if (last_bit) begin
        left_q  <= left_sr_d;
        right_q <= right_sr_d;
        valid_q <= 1'b1;
        if (valid_q && !sample_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign codec_adclrc   = lrc_q;
  assign audio_left_in  = left_q;
  assign audio_right_in = right_q;
  assign sample_valid   = valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: a codec model shifts queued frames once it
// sees the frame-sync pulse; monitors record captures and pulse widths.
module tb_audio_adc_rx;

  localparam int SB = 16;

  logic clk25 = 1'b0;
  logic reset25;
  logic bclk;
  logic adcdat;
  logic adclrc;
  logic samp_clk;

  audio_adc_rx_if #(.SAMPLE_BITS(SB)) rx_if ();

  audio_adc_rx #(.SAMPLE_BITS(SB)) dut (
    .clk25            (clk25),
    .reset25          (reset25),
    .codec_bclk_i     (bclk),
    .codec_adcdat     (adcdat),
    .codec_adclrc     (adclrc),
    .audio_sample_clk (samp_clk),
    .audio_left_in    (rx_if.left),
    .audio_right_in   (rx_if.right),
    .sample_valid     (rx_if.valid),
    .sample_ready     (rx_if.ready),
    .overrun          (rx_if.overrun)
  );

  always #20 clk25 = ~clk25;

  int tests = 0;
  int fails = 0;

  logic [31:0] frame_q[$];
  int          frame_rd = 0;
  logic [31:0] cap_q[$];
  int          lrc_pulses = 0;
  int          lrc_len = 0;
  int          vld_len = 0;
  int          vrise_cyc = 0;
  int          lrise_cyc = 0;
  int          base;
  int          ncap;

  // Codec: idles with the next frame's MSB on the line, shifts the rest after adclrc
  initial begin
    logic [31:0] cur;
    int          cod_idx;
    logic        cod_active;
    cur        = '0;
    cod_idx    = 0;
    cod_active = 1'b0;
    bclk       = 1'b0;
    adcdat     = 1'b0;
    forever begin
      @(negedge clk25);
      bclk = ~bclk;
      if (reset25) cod_active = 1'b0;
      if (!cod_active) begin
        if (adclrc && (frame_rd < frame_q.size())) begin
          cur        = frame_q[frame_rd];
          frame_rd   = frame_rd + 1;
          cod_active = 1'b1;
          cod_idx    = 1;
          adcdat     = cur[30];
        end else begin
          adcdat = (frame_rd < frame_q.size()) ? frame_q[frame_rd][31] : 1'b0;
        end
      end else if (!bclk) begin
        cod_idx = cod_idx + 1;
        if (cod_idx == 2 * SB) begin
          cod_active = 1'b0;
          adcdat     = (frame_rd < frame_q.size()) ? frame_q[frame_rd][31] : 1'b0;
        end else begin
          adcdat = cur[31 - cod_idx];
        end
      end
    end
  end

  initial begin
    int   cyc;
    int   vld_cur;
    int   lrc_cur;
    logic vld_d;
    logic lrc_d;
    cyc = 0; vld_cur = 0; lrc_cur = 0; vld_d = 1'b0; lrc_d = 1'b0;
    forever begin
      @(negedge clk25);
      cyc = cyc + 1;
      if (rx_if.valid && !vld_d) begin
        cap_q.push_back({rx_if.left, rx_if.right});
        vrise_cyc = cyc;
      end
      if (rx_if.valid) vld_cur = vld_cur + 1;
      else if (vld_d) begin vld_len = vld_cur; vld_cur = 0; end
      if (adclrc && !lrc_d) begin
        lrc_pulses = lrc_pulses + 1;
        lrise_cyc  = cyc;
      end
      if (adclrc) lrc_cur = lrc_cur + 1;
      else if (lrc_d) begin lrc_len = lrc_cur; lrc_cur = 0; end
      vld_d = rx_if.valid;
      lrc_d = adclrc;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk25);
    #5;
  endtask

  task automatic pulse_req();
    samp_clk = 1'b1;
    tick(2);
    samp_clk = 1'b0;
    tick(2);
  endtask

  task automatic wait_caps(input int n);
    for (int i = 0; i < 400 && cap_q.size() < n; i++) tick(1);
    chk("capture_count", 64'(cap_q.size()), 64'(n));
  endtask

  task automatic wait_lrc(input int n);
    for (int i = 0; i < 400 && lrc_pulses < n; i++) tick(1);
    chk("lrc_count", 64'(lrc_pulses), 64'(n));
  endtask

  initial begin
    reset25     = 1'b1;
    samp_clk    = 1'b0;
    rx_if.ready = 1'b0;
    tick(3);
    chk("rst_adclrc",  64'(adclrc), 64'd0);
    chk("rst_valid",   64'(rx_if.valid), 64'd0);
    chk("rst_overrun", 64'(rx_if.overrun), 64'd0);
    chk("rst_left",    64'({rx_if.left}), 64'd0);
    chk("rst_right",   64'({rx_if.right}), 64'd0);
    reset25 = 1'b0;
    tick(3);

    // Single frame, consumer not yet ready
    frame_q.push_back({16'hA5C3, 16'h1234});
    pulse_req();
    wait_caps(1);
    chk("f1_cap",       64'(cap_q[0]), 64'hA5C3_1234);
    chk("f1_left",      64'({rx_if.left}), 64'hA5C3);
    chk("f1_right",     64'({rx_if.right}), 64'h1234);
    chk("f1_lrc_count", 64'(lrc_pulses), 64'd1);
    chk("f1_lrc_len",   64'(lrc_len), 64'd2);
    chk("f1_overrun",   64'(rx_if.overrun), 64'd0);
    chk("f1_valid",     64'(rx_if.valid), 64'd1);
    rx_if.ready = 1'b1;
    tick(1);
    rx_if.ready = 1'b0;
    chk("f1_accept",    64'(rx_if.valid), 64'd0);

    // Extreme values with the consumer always ready
    rx_if.ready = 1'b1;
    frame_q.push_back({16'h8000, 16'h7FFF});
    pulse_req();
    wait_caps(2);
    tick(2);
    chk("rdy_len1", 64'(vld_len), 64'd1);
    frame_q.push_back({16'hFFFF, 16'h0000});
    pulse_req();
    wait_caps(3);
    tick(2);
    chk("rdy_cap1",    64'(cap_q[1]), 64'h8000_7FFF);
    chk("rdy_cap2",    64'(cap_q[2]), 64'hFFFF_0000);
    chk("rdy_len2",    64'(vld_len), 64'd1);
    chk("rdy_overrun", 64'(rx_if.overrun), 64'd0);

    // Two frames without acceptance
    rx_if.ready = 1'b0;
    frame_q.push_back({16'h1111, 16'h2222});
    frame_q.push_back({16'h3333, 16'h4444});
    pulse_req();
    wait_caps(4);
    base = lrc_pulses;
    pulse_req();
    wait_lrc(base + 1);
    tick(80);
    chk("ovr_valid",   64'(rx_if.valid), 64'd1);
    chk("ovr_left",    64'({rx_if.left}), 64'h3333);
    chk("ovr_right",   64'({rx_if.right}), 64'h4444);
    chk("ovr_flag",    64'(rx_if.overrun), 64'd1);
    rx_if.ready = 1'b1;
    tick(1);
    rx_if.ready = 1'b0;
    tick(1);
    chk("ovr_accept",  64'(rx_if.valid), 64'd0);
    chk("ovr_sticky",  64'(rx_if.overrun), 64'd1);
    reset25 = 1'b1;
    tick(1);
    chk("ovr_cleared", 64'(rx_if.overrun), 64'd0);
    reset25 = 1'b0;
    tick(2);

    // Request arriving mid-frame
    rx_if.ready = 1'b1;
    frame_q.push_back({16'hCAFE, 16'hBEEF});
    frame_q.push_back({16'h0F0F, 16'hF0F0});
    base = lrc_pulses;
    pulse_req();
    wait_lrc(base + 1);
    tick(42);
    pulse_req();
    wait_caps(5);
    tick(3);
    chk("mid_cap1",    64'(cap_q[4]), 64'hCAFE_BEEF);
    chk("mid_lrc_gap", 64'(lrise_cyc - vrise_cyc), 64'd1);
    chk("mid_lrc_cnt", 64'(lrc_pulses), 64'(base + 2));
    wait_caps(6);
    chk("mid_cap2",    64'(cap_q[5]), 64'h0F0F_F0F0);

    // Three requests inside one frame coalesce into one follow-on frame
    frame_q.push_back({16'h5A5A, 16'hA5A5});
    frame_q.push_back({16'h6B6B, 16'hB6B6});
    base = lrc_pulses;
    pulse_req();
    wait_lrc(base + 1);
    tick(6);
    pulse_req();
    tick(6);
    pulse_req();
    tick(6);
    pulse_req();
    tick(300);
    chk("coal_lrc",   64'(lrc_pulses), 64'(base + 2));
    chk("coal_caps",  64'(cap_q.size()), 64'd8);
    chk("coal_cap1",  64'(cap_q[6]), 64'h5A5A_A5A5);
    chk("coal_cap2",  64'(cap_q[7]), 64'h6B6B_B6B6);

    // Asynchronous reset in the middle of a frame
    rx_if.ready = 1'b0;
    frame_q.push_back({16'h1357, 16'h2468});
    pulse_req();
    wait_caps(9);
    chk("ar_pre_valid", 64'(rx_if.valid), 64'd1);
    frame_q.push_back({16'hDEAD, 16'hBEEF});
    base = lrc_pulses;
    pulse_req();
    wait_lrc(base + 1);
    tick(20);
    #7;
    reset25 = 1'b1;
    #1;
    chk("ar_valid",   64'(rx_if.valid), 64'd0);
    chk("ar_left",    64'({rx_if.left}), 64'd0);
    chk("ar_right",   64'({rx_if.right}), 64'd0);
    chk("ar_adclrc",  64'(adclrc), 64'd0);
    chk("ar_overrun", 64'(rx_if.overrun), 64'd0);
    tick(1);
    reset25 = 1'b0;
    ncap = cap_q.size();
    tick(200);
    chk("ar_no_cap",  64'(cap_q.size()), 64'(ncap));
    chk("ar_no_lrc",  64'(lrc_pulses), 64'(base + 1));
    chk("ar_idle",    64'(rx_if.valid), 64'd0);
    frame_q.push_back({16'h0246, 16'h8ACE});
    pulse_req();
    wait_caps(ncap + 1);
    chk("ar_new_cap", 64'(cap_q[ncap]), 64'h0246_8ACE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_adc_rx.md
AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 The module SHALL have parameter SAMPLE_BITS, default 16, giving the bits per channel; the frame length is 2*SAMPLE_BITS BCLK periods.
REQ-002 The module SHALL have port clk25, input, 1 bit: system clock, 25 MHz, the only clock.
REQ-003 The module SHALL have port reset25, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port codec_bclk_i, input, 1 bit: codec bit clock, asynchronous to clk25, at most clk25/2.
REQ-005 The module SHALL have port codec_adcdat, input, 1 bit: codec ADC serial data, MSB first, left channel then right.
REQ-006 The module SHALL have port codec_adclrc, output, 1 bit: ADC frame-sync pulse to the codec.
REQ-007 The module SHALL have port audio_sample_clk, input, 1 bit: frame request, clk25 domain; each rising edge requests one frame.
REQ-008 The module SHALL have port audio_left_in, output, SAMPLE_BITS bits: last captured left sample, two's complement.
REQ-009 The module SHALL have port audio_right_in, output, SAMPLE_BITS bits: last captured right sample, two's complement.
REQ-010 The module SHALL have port sample_valid, output, 1 bit: a captured sample pair is available.
REQ-011 The module SHALL have port sample_ready, input, 1 bit: the consumer accepts the pair.
REQ-012 The module SHALL have port overrun, output, 1 bit: sticky flag, set when an unaccepted pair is overwritten.

Function
REQ-013 codec_bclk_i and codec_adcdat SHALL pass through a 2-flop synchronizer plus one edge-detect register. Data SHALL be sampled from the same delayed stage as the detected BCLK edge.
REQ-014 A rising edge of audio_sample_clk (current high, previous low) SHALL set start_pending.
REQ-015 FSM states SHALL be IDLE, SYNC and SHIFT.
- IDLE: go to SYNC on a detected BCLK falling edge while start_pending=1.
- SYNC: go to SHIFT on the next BCLK rising edge.
- SHIFT: return to IDLE after the last bit is captured.
REQ-016 On the IDLE-to-SYNC falling edge, the module SHALL drive codec_adclrc=1, clear start_pending and clear bit_cntr. codec_adclrc SHALL return to 0 on the next detected BCLK falling edge, giving a one-BCLK-period pulse.
REQ-017 Capture SHALL happen on detected BCLK rising edges: the SYNC-exit edge and each following rising edge, 2*SAMPLE_BITS edges in total.
- Edges 0..SAMPLE_BITS-1 fill the left shift register, MSB first.
- The remaining edges fill the right shift register, MSB first.
REQ-018 bit_cntr SHALL be 6 bits wide; it increments on each capture and reaching 2*SAMPLE_BITS marks completion.
REQ-019 On completion, within the same clk25 cycle as the final capture, the module SHALL load audio_left_in and audio_right_in from the shift registers and set sample_valid=1.
- Latency from the last rising BCLK at the pin to sample_valid SHALL be at most 4 clk25 cycles.
REQ-020 sample_valid SHALL clear in the cycle after a cycle with sample_valid=1 and sample_ready=1.
- The output registers SHALL stay stable while sample_valid=1 unless overwritten (REQ-021).
REQ-021 If completion occurs while sample_valid=1 and sample_ready=0, the module SHALL overwrite the outputs, keep sample_valid=1 and set overrun=1.
- If sample_ready=1 in that same cycle, the module SHALL treat the old pair as accepted and SHALL NOT set overrun.
REQ-022 A sample-clock rising edge during SYNC or SHIFT SHALL set start_pending without disturbing the frame in progress. The pending request SHALL start at the first falling edge seen in IDLE.
REQ-023 Additional sample-clock edges while start_pending=1 SHALL be coalesced into the single pending request.

Reset
REQ-024 While reset25=1, regardless of clk25, the module SHALL hold these values:
- codec_adclrc=0, sample_valid=0, overrun=0;
- audio_left_in and audio_right_in all zeros;
- FSM in IDLE, start_pending=0, bit_cntr=0;
- synchronizer and edge flops at 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame. After deassertion, no capture SHALL occur until a new audio_sample_clk rising edge.

Structure
REQ-026 The FSM state encoding and SAMPLE_BITS default SHALL live in shared package audio_pkg, which the DAC side also uses.
REQ-027 The BCLK/data synchronizer with edge detect SHALL be a separate sub-module, bclk_sync, which outputs rise, fall and aligned data.

Verification
REQ-028 With BCLK=12.5 MHz, a codec model sending left=0xA5C3 and right=0x1234 after one sample-clk edge SHALL produce one adclrc pulse of 80 ns, then sample_valid with audio_left_in=0xA5C3 and audio_right_in=0x1234.
REQ-029 With frames 0x8000/0x7FFF then 0xFFFF/0x0000 and sample_ready held 1, the bench SHALL see both pairs in order, each sample_valid lasting 1 cycle, and overrun=0.
REQ-030 With sample_ready=0 across two frames, sample_valid SHALL stay 1, the outputs SHALL show the second pair, and overrun SHALL be 1 until reset.
REQ-031 A sample-clk edge at bit 20 of a frame SHALL leave the current frame intact, and the next adclrc pulse SHALL occur on the first falling edge after completion.
REQ-032 reset25 pulsed at bit 10 SHALL force all outputs to 0 immediately (asynchronous), with no sample_valid until a new sample-clk edge starts a full frame.
REQ-033 Three sample-clk edges inside one frame SHALL yield exactly one follow-on frame.
